// File: rtl/mr_mem_pkg.sv
// Shared size encodings and helpers for the MR memory data path
// (used by both the store formatter and the load formatter).
package mr_mem_pkg;

  typedef enum logic [1:0] {
    SZ_8   = 2'b00,
    SZ_16  = 2'b01,
    SZ_32  = 2'b10,
    SZ_ILL = 2'b11
  } mem_size_e;

  typedef enum logic {
    LD_IDLE   = 1'b0,
    LD_SECOND = 1'b1
  } ld_state_e;

  // Access width in bytes; the illegal encoding reports zero so it never crosses.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_8:    return 4'd1;
      SZ_16:   return 4'd2;
      SZ_32:   return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic is_crossing(input logic [1:0] size, input logic [2:0] address);
    return ({1'b0, address} + size_bytes(size)) > 4'd8;
  endfunction

endpackage

// File: rtl/ld_extract.sv
// Combinational byte gather, ordering and extension of one load value
// from a pair of consecutive big-endian doubleword beats.
module ld_extract #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic [127:0] beats,
  input  logic [1:0]   size,
  input  logic [2:0]   address,
  input  logic         sext,
  input  logic         brev,
  output logic [31:0]  value,
  output logic         err
);
  import mr_mem_pkg::*;

  logic [7:0]  b [4];
  logic [15:0] half;
  logic        crossing;
  logic        illegal;

  // Memory bytes 8..10 live in the low bytes of the second beat.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i] = beats[{4'(address) + 4'(i), 3'b000} +: 8];
    end
  end

  always_comb begin
    illegal  = (size == SZ_ILL);
    crossing = is_crossing(size, address);
    err      = illegal || (crossing && !SPLIT_EN);
    half     = brev ? {b[1], b[0]} : {b[0], b[1]};
    value    = 32'h0;
    if (!err) begin
      case (size)
        SZ_8:    value = {{24{sext & b[0][7]}}, b[0]};
        SZ_16:   value = {{16{sext & half[15]}}, half};
        SZ_32:   value = brev ? {b[3], b[2], b[1], b[0]} : {b[0], b[1], b[2], b[3]};
        default: value = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/datafmt6432.sv
// Load-side data formatter: merges boundary-crossing beats, extracts and
// extends the load value, and presents it through one registered output stage.
module datafmt6432 #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_size,
  input  logic [2:0]  in_address,
  input  logic        in_sext,
  input  logic        in_brev,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);
  import mr_mem_pkg::*;

  ld_state_e   state;
  ld_state_e   next_state;

  logic [63:0] hold_data;
  logic [1:0]  hold_size;
  logic [2:0]  hold_addr;
  logic        hold_sext;
  logic        hold_brev;

  logic [127:0] x_beats;
  logic [1:0]   x_size;
  logic [2:0]   x_addr;
  logic         x_sext;
  logic         x_brev;
  logic [31:0]  x_value;
  logic         x_err;

  logic first_split;
  logic accept;
  logic load_out;
  logic capture;

  // A crossing first beat only fills the hold register, so it never waits on the output.
  assign first_split = (state == LD_IDLE) && SPLIT_EN && is_crossing(in_size, in_address);
  assign in_ready    = reset_n && (!out_valid || out_ready || first_split);
  assign accept      = in_valid && in_ready;

  always_comb begin
    x_beats = {in_data, in_data};
    x_size  = in_size;
    x_addr  = in_address;
    x_sext  = in_sext;
    x_brev  = in_brev;
    if (state == LD_SECOND) begin
      x_beats = {in_data, hold_data};
      x_size  = hold_size;
      x_addr  = hold_addr;
      x_sext  = hold_sext;
      x_brev  = hold_brev;
    end
  end

  ld_extract #(
    .SPLIT_EN(SPLIT_EN)
  ) u_extract (
    .beats  (x_beats),
    .size   (x_size),
    .address(x_addr),
    .sext   (x_sext),
    .brev   (x_brev),
    .value  (x_value),
    .err    (x_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= LD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_out   = 1'b0;
    capture    = 1'b0;
    case (state)
      LD_IDLE: begin
        if (accept) begin
          if (first_split) begin
            capture    = 1'b1;
            next_state = LD_SECOND;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      LD_SECOND: begin
        if (accept) begin
          load_out   = 1'b1;
          next_state = LD_IDLE;
        end
      end
      default: next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_data <= 64'h0;
      hold_size <= 2'b00;
      hold_addr <= 3'd0;
      hold_sext <= 1'b0;
      hold_brev <= 1'b0;
    end else if (capture) begin
      hold_data <= in_data;
      hold_size <= in_size;
      hold_addr <= in_address;
      hold_sext <= in_sext;
      hold_brev <= in_brev;
    end
  end

  // Reloading wins over consumption so back-to-back results never bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_err   <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= x_value;
      out_err   <= x_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
